// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, operation classes and sequencer state encoding.
package alu_pkg;

  localparam logic [4:0] ALU_OP_AND = 5'b00000;
  localparam logic [4:0] ALU_OP_OR  = 5'b00001;
  localparam logic [4:0] ALU_OP_XOR = 5'b00010;
  localparam logic [4:0] ALU_OP_ADD = 5'b00011;
  localparam logic [4:0] ALU_OP_SUB = 5'b00100;
  localparam logic [4:0] ALU_OP_MUL = 5'b10011;
  localparam logic [4:0] ALU_OP_DIV = 5'b10100;

  // Single-cycle opcodes form two ranges around the reserved 01100/01101 hole.
  localparam logic [4:0] ALU_OP_SGL0_LAST  = 5'b01011;
  localparam logic [4:0] ALU_OP_SGL1_FIRST = 5'b01110;
  localparam logic [4:0] ALU_OP_SGL1_LAST  = 5'b10010;

  typedef enum logic [1:0] {
    CLS_SINGLE,
    CLS_MUL,
    CLS_DIV,
    CLS_ILLEGAL
  } op_cls_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT_MUL,
    ST_WAIT_DIV,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier; shared with the control unit.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [4:0] op,
  output op_cls_e    cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (op == ALU_OP_MUL) begin
      cls = CLS_MUL;
    end else if (op == ALU_OP_DIV) begin
      cls = CLS_DIV;
    end else if ((op <= ALU_OP_SGL0_LAST) ||
                 ((op >= ALU_OP_SGL1_FIRST) && (op <= ALU_OP_SGL1_LAST))) begin
      cls = CLS_SINGLE;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response controller in front of the ALU and divider.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the rsp_zero output.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_c,
  output logic        div_start,
  input  logic        div_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        err_op,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic        rsp_zero,
`endif
  output logic        busy
);

  localparam int CNT_MAX = (MUL_LAT > DIV_TIMEOUT) ? MUL_LAT : DIV_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

  seq_state_e       state;
  op_cls_e          req_cls;
  logic [CNT_W-1:0] cnt;

  logic        cap_en;
  logic        cap_err;
  logic [31:0] cap_lo;
  logic [31:0] cap_hi;

  alu_op_decode u_decode (
    .op  (req_op),
    .cls (req_cls)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Decide whether this cycle ends the operation and what the response carries.
  always_comb begin
    cap_en  = 1'b0;
    cap_err = 1'b0;
    cap_lo  = '0;
    cap_hi  = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid && (req_cls == CLS_ILLEGAL)) begin
          cap_en  = 1'b1;
          cap_err = 1'b1;
        end
      end
      ST_EXEC: begin
        cap_en = 1'b1;
        cap_lo = alu_c[31:0];
      end
      ST_WAIT_MUL: begin
        if (cnt == MUL_LAST) begin
          cap_en = 1'b1;
          cap_lo = alu_c[31:0];
          cap_hi = alu_c[63:32];
        end
      end
      ST_WAIT_DIV: begin
        if (div_done) begin
          cap_en = 1'b1;
          cap_lo = alu_c[31:0];
        end else if (cnt == DIV_LAST) begin
          cap_en  = 1'b1;
          cap_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      div_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      err_op    <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      div_start <= 1'b0;
      if (cap_en) begin
        state     <= ST_RESP;
        cnt       <= '0;
        rsp_valid <= 1'b1;
        rsp_lo    <= cap_lo;
        rsp_hi    <= cap_hi;
        err_op    <= cap_err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        rsp_zero  <= ({cap_hi, cap_lo} == 64'd0) && !cap_err;
`endif
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_a  <= req_a;
            alu_b  <= req_b;
            alu_op <= req_op;
            cnt    <= '0;
            case (req_cls)
              CLS_SINGLE: state <= ST_EXEC;
              CLS_MUL:    state <= ST_WAIT_MUL;
              CLS_DIV: begin
                state     <= ST_WAIT_DIV;
                div_start <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_EXEC: ;
        ST_WAIT_MUL, ST_WAIT_DIV: begin
          if (!cap_en) cnt <= cnt + CNT_W'(1);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU/divider, vector table and corner sequences.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int MUL_LAT     = 2;
  localparam int DIV_TIMEOUT = 64;

  logic        clk;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_c;
  logic        div_start;
  logic        div_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        err_op;
  logic        busy;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .div_start (div_start),
    .div_done  (div_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .err_op    (err_op),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero  (rsp_zero),
`endif
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU model: multiply only settles after MUL_LAT stable cycles; upper bits are junk except for MUL.
  logic [68:0] cur_key, prev_key;
  int          mul_age;
  int          stable;
  logic [63:0] prod;
  assign cur_key = {alu_op, alu_a, alu_b};
  assign stable  = (cur_key != prev_key) ? 0 : mul_age;
  assign prod    = {32'd0, alu_a} * {32'd0, alu_b};

  always @(posedge clk) begin
    prev_key <= cur_key;
    if (cur_key != prev_key) mul_age <= 1;
    else if (mul_age < 1000) mul_age <= mul_age + 1;
  end

  // Divider model: div_done pulses div_delay cycles after the div_start cycle (<=0: never).
  int          div_delay;
  int          dcnt;
  logic        div_run;
  logic        div_done_m;
  logic        div_spur;
  logic [31:0] div_q;
  assign div_done = div_done_m | div_spur;

  always @(posedge clk) begin
    div_done_m <= 1'b0;
    if (clr) begin
      div_run <= 1'b0;
    end else if (div_start) begin
      div_run <= (div_delay > 1);
      dcnt    <= div_delay - 1;
      div_q   <= (alu_b != 0) ? alu_a / alu_b : 32'hFFFF_FFFF;
    end else if (div_run) begin
      if (dcnt == 1) begin
        div_done_m <= 1'b1;
        div_run    <= 1'b0;
      end else begin
        dcnt <= dcnt - 1;
      end
    end
  end

  always_comb begin
    case (alu_op)
      ALU_OP_AND: alu_c = {32'hA5A5_A5A5, alu_a & alu_b};
      ALU_OP_OR:  alu_c = {32'hA5A5_A5A5, alu_a | alu_b};
      ALU_OP_XOR: alu_c = {32'hA5A5_A5A5, alu_a ^ alu_b};
      ALU_OP_ADD: alu_c = {32'hA5A5_A5A5, alu_a + alu_b};
      ALU_OP_SUB: alu_c = {32'hA5A5_A5A5, alu_a - alu_b};
      ALU_OP_MUL: alu_c = (stable >= MUL_LAT - 1) ? prod : 64'hDEAD_BEEF_DEAD_BEEF;
      ALU_OP_DIV: alu_c = div_done ? {32'h5A5A_5A5A, div_q} : 64'hFFFF_FFFF_FFFF_FFFF;
      default:    alu_c = {32'hA5A5_A5A5, alu_a + alu_b + {27'd0, alu_op}};
    endcase
  end

  int n_start;
  always @(posedge clk) if (div_start) n_start <= n_start + 1;
  initial n_start = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int          dly;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[21];
  int   n_vec;
  int   n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    int   guard;
    int   lat;
    int   base;
    exp_t e;
    logic [31:0] snap_lo, snap_hi;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before", 64'(req_ready), 64'd1);
    div_delay = v.dly;
    base      = n_start;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back('{v.lo, v.hi, v.err});
    chk("latched", {27'd0, alu_op, alu_a}, {27'd0, v.op, v.a});
    chk("latched_b", 64'(alu_b), 64'(v.b));
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(v.lat));
    snap_lo = rsp_lo;
    snap_hi = rsp_hi;
    if (v.hold > 0) begin
      req_valid = 1'b1;
      req_op    = ALU_OP_XOR;
      req_a     = ~v.a;
    end
    for (int i = 0; i < v.hold; i++) begin
      chk("hold_lo", 64'(rsp_lo), 64'(snap_lo));
      chk("hold_hi", 64'(rsp_hi), 64'(snap_hi));
      chk("hold_ctl", {61'd0, rsp_valid, req_ready, err_op}, {61'd0, 1'b1, 1'b0, v.err});
      chk("hold_alu", {27'd0, alu_op, alu_a}, {27'd0, v.op, v.a});
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, want entry");
    end else begin
      e = sb.pop_front();
      chk("rsp_lo", 64'(rsp_lo), 64'(e.lo));
      chk("rsp_hi", 64'(rsp_hi), 64'(e.hi));
      chk("err_op", 64'(err_op), 64'(e.err));
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk("rsp_zero", 64'(rsp_zero), 64'((e.lo == 0) && (e.hi == 0) && !e.err));
`endif
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release", {61'd0, rsp_valid, req_ready, busy}, 64'b010);
    chk("div_starts", 64'(n_start - base), 64'(v.op == ALU_OP_DIV));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    clr       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    div_spur  = 1'b0;
    div_delay = 0;

    //            op          a             b             lo            hi     err  dly lat hold
    tbl[0]  = '{ALU_OP_ADD, 32'd5,        32'd7,        32'd12,       32'd0, 1'b0, 0,  2,  0};
    tbl[1]  = '{ALU_OP_AND, 32'hF0F0,     32'hFF00,     32'hF000,     32'd0, 1'b0, 0,  2,  5};
    tbl[2]  = '{ALU_OP_OR,  32'hF0F0,     32'hFF00,     32'hFFF0,     32'd0, 1'b0, 0,  2,  0};
    tbl[3]  = '{ALU_OP_XOR, 32'hF0F0,     32'hFF00,     32'h0FF0,     32'd0, 1'b0, 0,  2,  0};
    tbl[4]  = '{ALU_OP_SUB, 32'd10,       32'd3,        32'd7,        32'd0, 1'b0, 0,  2,  0};
    tbl[5]  = '{ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1,       32'd0,        32'd0, 1'b0, 0,  2,  0};
    tbl[6]  = '{5'b01011,   32'd0,        32'd0,        32'd11,       32'd0, 1'b0, 0,  2,  0};
    tbl[7]  = '{5'b01110,   32'd1,        32'd2,        32'd17,       32'd0, 1'b0, 0,  2,  0};
    tbl[8]  = '{5'b10010,   32'd0,        32'd0,        32'd18,       32'd0, 1'b0, 0,  2,  0};
    tbl[9]  = '{5'b01100,   32'd3,        32'd4,        32'd0,        32'd0, 1'b1, 0,  1,  0};
    tbl[10] = '{5'b01101,   32'd3,        32'd4,        32'd0,        32'd0, 1'b1, 0,  1,  0};
    tbl[11] = '{5'b10101,   32'd3,        32'd4,        32'd0,        32'd0, 1'b1, 0,  1,  0};
    tbl[12] = '{5'b11111,   32'd9,        32'd9,        32'd0,        32'd0, 1'b1, 0,  1,  3};
    tbl[13] = '{ALU_OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,      32'd1, 1'b0, 0,  MUL_LAT + 1, 0};
    tbl[14] = '{ALU_OP_MUL, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE, 32'd1, 1'b0, 0, MUL_LAT + 1, 2};
    tbl[15] = '{ALU_OP_MUL, 32'd3,        32'd5,        32'd15,       32'd0, 1'b0, 0,  MUL_LAT + 1, 0};
    tbl[16] = '{ALU_OP_DIV, 32'd100,      32'd7,        32'd14,       32'd0, 1'b0, 10, 12, 0};
    tbl[17] = '{ALU_OP_DIV, 32'd9,        32'd3,        32'd3,        32'd0, 1'b0, 2,  4,  0};
    tbl[18] = '{ALU_OP_DIV, 32'd100,      32'd7,        32'd0,        32'd0, 1'b1, -1, DIV_TIMEOUT + 1, 0};
    tbl[19] = '{ALU_OP_DIV, 32'd1000,     32'd10,       32'd100,      32'd0, 1'b0, DIV_TIMEOUT - 1, DIV_TIMEOUT + 1, 0};
    tbl[20] = '{ALU_OP_DIV, 32'd1000,     32'd10,       32'd0,        32'd0, 1'b1, DIV_TIMEOUT, DIV_TIMEOUT + 1, 0};

    @(posedge clk); #1;
    chk("rst_ready_busy", {62'd0, req_ready, busy}, 64'b10);
    chk("rst_rsp", {61'd0, rsp_valid, err_op, div_start}, 64'd0);
    chk("rst_data", {rsp_hi, rsp_lo}, 64'd0);
    chk("rst_alu", {27'd0, alu_op, alu_a | alu_b}, 64'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst_zero", 64'(rsp_zero), 64'd0);
`endif
    clr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) do_op(tbl[i]);

    // A stray div_done while idle must not start anything.
    div_spur = 1'b1;
    @(posedge clk); #1;
    div_spur = 1'b0;
    @(posedge clk); #1;
    chk("spur_done", {62'd0, busy, rsp_valid}, 64'd0);

    // Reset in the middle of a divide that never completes.
    div_delay = -1;
    req_op    = ALU_OP_DIV;
    req_a     = 32'd50;
    req_b     = 32'd5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("clr_div_start", 64'(div_start), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("clr_busy_before", {62'd0, busy, div_start}, 64'b10);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_after", {60'd0, req_ready, busy, rsp_valid, div_start}, 64'b1000);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("clr_quiet", {62'd0, rsp_valid, busy}, 64'd0);

    do_op(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
